// File: rtl/mem_access_ctrl.sv
// Sequences one CPU read/write per valid/ready handshake into setup/strobe/hold cycles on a combinational memory.
// Response arrives WAIT_CYCLES+2 cycles after accept; req_ready is low while busy, and responses are never stalled.
module mem_access_ctrl #(
  parameter int ADDR_W      = 12,
  parameter int DATA_W      = 16,
  parameter int WAIT_CYCLES = 1
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              req_valid,
  output logic              req_ready,
  input  logic              req_write,
  input  logic [ADDR_W-1:0] req_addr,
  input  logic [DATA_W-1:0] req_wdata,
  output logic              rsp_valid,
  output logic [DATA_W-1:0] rsp_rdata,
  output logic [ADDR_W-1:0] mem_adress,
  output logic              mem_read,
  output logic              mem_write,
  output logic [DATA_W-1:0] mem_indata,
  input  logic [DATA_W-1:0] mem_outdata
);

  generate
    if (WAIT_CYCLES < 1 || WAIT_CYCLES > 15) begin : g_bad_wait
      $error("mem_access_ctrl: WAIT_CYCLES=%0d outside 1..15", WAIT_CYCLES);
    end
  endgenerate

  typedef enum logic [1:0] {IDLE, SETUP, STROBE, HOLD} state_t;

  state_t     state;
  logic [3:0] cnt;
  logic       we;

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state      <= IDLE;
      req_ready  <= 1'b1;
      rsp_valid  <= 1'b0;
      rsp_rdata  <= '0;
      mem_adress <= '0;
      mem_read   <= 1'b0;
      mem_write  <= 1'b0;
      mem_indata <= '0;
      cnt        <= '0;
      we         <= 1'b0;
    end else begin
      case (state)
        IDLE: begin
          rsp_valid <= 1'b0;
          if (req_valid && req_ready) begin
            mem_adress <= req_addr;
            mem_indata <= req_wdata;
            we         <= req_write;
            req_ready  <= 1'b0;
            state      <= SETUP;
          end
        end
        SETUP: begin
          // Address and data have been stable for a full cycle before either strobe rises.
          cnt       <= 4'(WAIT_CYCLES - 1);
          mem_write <= we;
          mem_read  <= ~we;
          state     <= STROBE;
        end
        STROBE: begin
          if (cnt == 4'd0) begin
            mem_read  <= 1'b0;
            mem_write <= 1'b0;
            rsp_valid <= 1'b1;
            if (!we) rsp_rdata <= mem_outdata;
            state     <= HOLD;
          end else begin
            cnt <= cnt - 4'd1;
          end
        end
        HOLD: begin
          rsp_valid <= 1'b0;
          req_ready <= 1'b1;
          state     <= IDLE;
        end
        default: begin
          mem_read  <= 1'b0;
          mem_write <= 1'b0;
          rsp_valid <= 1'b0;
          req_ready <= 1'b1;
          state     <= IDLE;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_mem_access_ctrl.sv
// Drives two controllers (WAIT_CYCLES 1 and 3) on behavioural memories, comparing against a word-level scoreboard.
module tb_mem_access_ctrl;

  logic        clk = 1'b0;
  logic        reset;
  logic        req_valid   [2];
  logic        req_ready   [2];
  logic        req_write   [2];
  logic [11:0] req_addr    [2];
  logic [15:0] req_wdata   [2];
  logic        rsp_valid   [2];
  logic [15:0] rsp_rdata   [2];
  logic [11:0] mem_adress  [2];
  logic        mem_read    [2];
  logic        mem_write   [2];
  logic [15:0] mem_indata  [2];
  logic [15:0] mem_outdata [2];

  int n_chk  = 0;
  int n_fail = 0;

  logic [15:0] ref_mem   [2][4096];
  bit          ref_known [2][4096];
  logic [15:0] last_rd   [2];
  bit          last_known[2];

  always #5 clk = ~clk;

  genvar g;
  generate
    for (g = 0; g < 2; g++) begin : g_dut
      logic [15:0] mem [4096];

      mem_access_ctrl #(
        .ADDR_W(12), .DATA_W(16), .WAIT_CYCLES(g == 0 ? 1 : 3)
      ) u_dut (
        .clk        (clk),
        .reset      (reset),
        .req_valid  (req_valid[g]),
        .req_ready  (req_ready[g]),
        .req_write  (req_write[g]),
        .req_addr   (req_addr[g]),
        .req_wdata  (req_wdata[g]),
        .rsp_valid  (rsp_valid[g]),
        .rsp_rdata  (rsp_rdata[g]),
        .mem_adress (mem_adress[g]),
        .mem_read   (mem_read[g]),
        .mem_write  (mem_write[g]),
        .mem_indata (mem_indata[g]),
        .mem_outdata(mem_outdata[g])
      );

      assign mem_outdata[g] = mem[mem_adress[g]];
      always @(posedge clk) if (mem_write[g]) mem[mem_adress[g]] <= mem_indata[g];
    end
  endgenerate

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_chk++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h at %0t", tag, got, exp, $time);
    end
  endtask

  function automatic int wc(input int k);
    return (k == 0) ? 1 : 3;
  endfunction

  always @(negedge clk) begin
    for (int k = 0; k < 2; k++)
      check($sformatf("excl%0d", k), 32'(mem_read[k] & mem_write[k]), 32'd0);
  end

  task automatic check_reset_outputs(input string tag);
    for (int k = 0; k < 2; k++) begin
      check($sformatf("%s_ready%0d", tag, k), 32'(req_ready[k]), 32'd1);
      check($sformatf("%s_rspv%0d", tag, k), 32'(rsp_valid[k]), 32'd0);
      check($sformatf("%s_rdata%0d", tag, k), 32'(rsp_rdata[k]), 32'd0);
      check($sformatf("%s_addr%0d", tag, k), 32'(mem_adress[k]), 32'd0);
      check($sformatf("%s_rd%0d", tag, k), 32'(mem_read[k]), 32'd0);
      check($sformatf("%s_wr%0d", tag, k), 32'(mem_write[k]), 32'd0);
      check($sformatf("%s_ind%0d", tag, k), 32'(mem_indata[k]), 32'd0);
      last_rd[k]    = 16'h0;
      last_known[k] = 1'b1;
    end
  endtask

  // Called at a falling edge; reset is pulsed entirely between clock edges.
  task automatic reset_pulse(input string tag);
    for (int k = 0; k < 2; k++) req_valid[k] = 1'b0;
    #1 reset = 1'b1;
    #1 check_reset_outputs(tag);
    #1 reset = 1'b0;
  endtask

  // Wait for acceptance, then check every cycle of the access against the timing rules.
  task automatic access(input int k, input bit wr, input logic [11:0] a, input logic [15:0] d,
                        input bit busy);
    int w = wc(k);
    int n = 0;
    req_valid[k] = 1'b1;
    req_write[k] = wr;
    req_addr[k]  = a;
    req_wdata[k] = d;
    while (!req_ready[k] && n < 50) begin
      @(negedge clk);
      n++;
    end
    if (!req_ready[k]) begin
      check($sformatf("accept_timeout%0d", k), 32'd0, 32'd1);
      req_valid[k] = 1'b0;
      return;
    end
    @(posedge clk);
    for (int c = 1; c <= w + 2; c++) begin
      @(negedge clk);
      check($sformatf("rd%0d_c%0d", k, c), 32'(mem_read[k]), 32'(!wr && c >= 2 && c <= w + 1));
      check($sformatf("wr%0d_c%0d", k, c), 32'(mem_write[k]), 32'(wr && c >= 2 && c <= w + 1));
      check($sformatf("rspv%0d_c%0d", k, c), 32'(rsp_valid[k]), 32'(c == w + 2));
      check($sformatf("busy%0d_c%0d", k, c), 32'(req_ready[k]), 32'd0);
      check($sformatf("addr%0d_c%0d", k, c), 32'(mem_adress[k]), 32'(a));
      check($sformatf("ind%0d_c%0d", k, c), 32'(mem_indata[k]), 32'(d));
      if (c == w + 2 && !wr && ref_known[k][a])
        check($sformatf("rdata%0d_%03h", k, a), 32'(rsp_rdata[k]), 32'(ref_mem[k][a]));
      if (c == w + 2 && wr && last_known[k])
        check($sformatf("rdata_keep%0d", k), 32'(rsp_rdata[k]), 32'(last_rd[k]));
      if (!busy || c == w + 2) begin
        req_valid[k] = 1'b0;
      end else begin
        req_addr[k]  = 12'($urandom);
        req_wdata[k] = 16'($urandom);
        req_write[k] = 1'($urandom);
      end
    end
    if (wr) begin
      ref_mem[k][a]   = d;
      ref_known[k][a] = 1'b1;
    end else begin
      last_rd[k]    = ref_mem[k][a];
      last_known[k] = ref_known[k][a];
    end
    @(negedge clk);
    check($sformatf("idle_ready%0d", k), 32'(req_ready[k]), 32'd1);
    check($sformatf("idle_rspv%0d", k), 32'(rsp_valid[k]), 32'd0);
    check($sformatf("idle_addr%0d", k), 32'(mem_adress[k]), 32'(a));
  endtask

  initial begin
    for (int k = 0; k < 2; k++) begin
      req_valid[k] = 1'b0;
      req_write[k] = 1'b0;
      req_addr[k]  = '0;
      req_wdata[k] = '0;
      last_rd[k]   = '0;
      last_known[k] = 1'b1;
      for (int i = 0; i < 4096; i++) begin
        ref_mem[k][i]   = '0;
        ref_known[k][i] = 1'b0;
      end
    end
    reset = 1'b0;
    #1 reset = 1'b1;
    #1 check_reset_outputs("por");
    @(negedge clk);
    reset = 1'b0;
    @(negedge clk);

    // Write then read, W=1
    access(0, 1'b1, 12'h123, 16'h0ABC, 1'b0);
    access(0, 1'b0, 12'h123, 16'h5555, 1'b0);
    check("rdata_after_read_w1", 32'(rsp_rdata[0]), 32'h0ABC);

    // W=3 read of the top address
    access(1, 1'b1, 12'hFFF, 16'h8001, 1'b0);
    access(1, 1'b0, 12'hFFF, 16'h0000, 1'b0);
    check("rdata_after_read_w3", 32'(rsp_rdata[1]), 32'h8001);

    // Requester holds valid and wiggles the request while busy
    access(0, 1'b0, 12'h123, 16'h1111, 1'b1);
    access(1, 1'b1, 12'h0A5, 16'hBEEF, 1'b1);
    access(1, 1'b0, 12'h0A5, 16'h2222, 1'b1);

    // Reset during a read strobe
    req_valid[1] = 1'b1; req_write[1] = 1'b0; req_addr[1] = 12'h0A5; req_wdata[1] = 16'h0;
    @(posedge clk);
    @(negedge clk);
    req_valid[1] = 1'b0;
    @(negedge clk);
    check("mid_read_strobe", 32'(mem_read[1]), 32'd1);
    reset_pulse("rst_mid");

    // Reset during a write strobe: no response, then a normal read
    req_valid[1] = 1'b1; req_write[1] = 1'b1; req_addr[1] = 12'h0A5; req_wdata[1] = 16'h7777;
    @(negedge clk);
    @(posedge clk);
    @(negedge clk);
    req_valid[1] = 1'b0;
    @(negedge clk);
    check("wr_strobe_c2", 32'(mem_write[1]), 32'd1);
    @(negedge clk);
    check("wr_strobe_c3", 32'(mem_write[1]), 32'd1);
    reset_pulse("rst_wr");
    ref_known[1][12'h0A5] = 1'b0;
    for (int i = 0; i < 5; i++) begin
      @(negedge clk);
      check("post_rst_rspv", 32'(rsp_valid[1]), 32'd0);
      check("post_rst_ready", 32'(req_ready[1]), 32'd1);
    end
    access(1, 1'b0, 12'hFFF, 16'h0, 1'b0);
    check("post_rst_read", 32'(rsp_rdata[1]), 32'h8001);

    // Randomised traffic against the scoreboard
    for (int i = 0; i < 1000; i++) begin
      int          k;
      bit          wr;
      logic [11:0] a;
      k  = int'($urandom_range(0, 1));
      wr = 1'($urandom_range(0, 1));
      a  = ($urandom_range(0, 9) == 0) ? 12'hFFF : 12'($urandom_range(0, 31));
      access(k, wr, a, 16'($urandom), $urandom_range(0, 7) == 0);
    end

    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end

  initial begin
    #2000000;
    $display("FAIL global_timeout: got running expected finished");
    $fatal(1, "timeout");
  end

endmodule
